// File: rtl/uart_loopback_fifo_if.sv
// Handshake bundle between the uart_rx/uart_tx pair and the loopback FIFO.
// slave: seen from the FIFO; master: seen from the UART side / environment.
interface uart_loopback_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_d_i;
  logic          rx_done_i;
  logic [7:0]    tx_d_o;
  logic          tx_e_o;
  logic          tx_busy_i;
  logic [LW-1:0] level_o;
  logic          empty_o;
  logic          full_o;
  logic          overflow_o;
  logic          clr_overflow_i;

  modport slave (
    input  rx_d_i, rx_done_i, tx_busy_i, clr_overflow_i,
    output tx_d_o, tx_e_o, level_o, empty_o, full_o, overflow_o
  );

  modport master (
    output rx_d_i, rx_done_i, tx_busy_i, clr_overflow_i,
    input  tx_d_o, tx_e_o, level_o, empty_o, full_o, overflow_o
  );
endinterface

// File: rtl/uart_loopback_fifo.sv
// Byte FIFO and transmit sequencer for the uart_rx -> uart_tx loopback path.
// Received bytes are queued on rx_done_i and drained into uart_tx with an
// enable/busy handshake; a launch not acknowledged by tx_busy_i within
// BUSY_TIMEOUT cycles is retried with the same byte.
// Optional feature: define UART_LB_CRLF_EN to append 0x0A after every 0x0D sent.
module uart_loopback_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  uart_loopback_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_next;
  logic          empty_r, full_r, overflow;
  logic [7:0]    tx_d;
  logic          hold;
  logic [CW-1:0] cnt;
  logic          push, pop, drop;
  logic          load_head, retry;
`ifdef UART_LB_CRLF_EN
  logic          crlf_pend;
  logic          send_lf;
`endif

  // In LAUNCH the byte is popped unless it is a retry (or a generated LF)
  assign pop  = (state == LAUNCH) && !hold;
  assign push = bus.rx_done_i && (!full_r || pop);
  assign drop = bus.rx_done_i && !push;

  // Occupancy after this cycle's push/pop
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // Next-state logic for the transmit sequencer
  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    retry      = 1'b0;
`ifdef UART_LB_CRLF_EN
    send_lf    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty_r && !bus.tx_busy_i) begin
          state_next = LAUNCH;
          load_head  = 1'b1;
        end
      end
      LAUNCH: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy_i) begin
          state_next = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          state_next = LAUNCH;
          retry      = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy_i) begin
          state_next = IDLE;
`ifdef UART_LB_CRLF_EN
          if (crlf_pend) begin
            state_next = LAUNCH;
            send_lf    = 1'b1;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register and busy-timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state == WAIT_BUSY) ? cnt + CW'(1) : '0;
    end
  end

  // FIFO storage; no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_d_i;
  end

  // Pointers, registered level/flags and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_next;
      empty_r <= (level_next == '0);
      full_r  <= (level_next == LW'(DEPTH));
      if (drop)                    overflow <= 1'b1;
      else if (bus.clr_overflow_i) overflow <= 1'b0;
    end
  end

  // Head byte is captured on the way into LAUNCH so tx_d_o is valid with tx_e_o;
  // the read pointer then advances at the end of LAUNCH (the pop).
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_d <= '0;
      hold <= 1'b0;
    end else if (load_head) begin
      tx_d <= mem[rd_ptr];
      hold <= 1'b0;
    end else if (retry) begin
      hold <= 1'b1;
`ifdef UART_LB_CRLF_EN
    end else if (send_lf) begin
      tx_d <= 8'h0A;
      hold <= 1'b1;
`endif
    end
  end

`ifdef UART_LB_CRLF_EN
  // Remember a popped CR until its transfer completes
  always_ff @(posedge clk) begin
    if (reset)                    crlf_pend <= 1'b0;
    else if (pop && tx_d == 8'h0D) crlf_pend <= 1'b1;
    else if (send_lf)             crlf_pend <= 1'b0;
  end
`endif

  assign bus.tx_d_o     = tx_d;
  assign bus.tx_e_o     = (state == LAUNCH);
  assign bus.level_o    = level;
  assign bus.empty_o    = empty_r;
  assign bus.full_o     = full_r;
  assign bus.overflow_o = overflow;
endmodule
